// File: rtl/jtag_reg_master_pkg.sv
// ---------------------------------------------------------------------------
// jtag_reg_master_pkg
//   Shared definitions for the JTAG register-bus master:
//   - state_e                  : 2-bit FSM state encoding
//   - TIMEOUT_RD_DATA_DEFAULT  : read data returned when an access times out
//   - TIMEOUT_CNT_W            : width of the timed-out-access counter
//   - sat_inc()                : saturating increment for that counter
// ---------------------------------------------------------------------------
package jtag_reg_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a request in the FIFO
    ST_REQ  = 2'd1,  // reg_req high, waiting for ack or timeout
    ST_RESP = 2'd2,  // response cycle, read strobe goes out here
    ST_GAP  = 2'd3   // forced idle so reg_req stays low between accesses
  } state_e;

  localparam logic [31:0] TIMEOUT_RD_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int TIMEOUT_CNT_W = 16;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [TIMEOUT_CNT_W-1:0] sat_inc(
    input logic [TIMEOUT_CNT_W-1:0] value
  );
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/jtag_req_timer.sv
// ---------------------------------------------------------------------------
// jtag_req_timer
//   Access timer for jtag_reg_master. Cleared when a request is issued,
//   counts while enabled, flags expiry on its last count and holds there.
//   Ports:
//     i_clk     clock
//     i_rst     asynchronous active-high reset
//     i_clr     clear count to zero (has priority over i_en)
//     i_en      count enable
//     o_expire  high while count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module jtag_req_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_expire;

  assign w_expire = (r_count == LAST_CNT);
  assign o_expire = w_expire;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_expire) begin
      // Hold at the last count so the counter can never wrap.
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_reg_master.sv
// ---------------------------------------------------------------------------
// jtag_reg_master
//   Register-bus master fed by the JTAG request FIFO. Pops one request at a
//   time, drives the reg_req/reg_ack handshake, returns read data on
//   bus_rd_data/bus_rd_vld and aborts any access that is not acknowledged
//   within TIMEOUT_CYCLES cycles.
//   Ports:
//     core_clk      clock
//     reset         asynchronous active-high reset
//     fifo_empty    request FIFO empty (show-ahead, q valid when low)
//     fifo_rd_en    pop strobe to the request FIFO (combinational, IDLE only)
//     bus_rd_wr_L   FIFO q: 1 = read, 0 = write
//     bus_addr      FIFO q: address
//     bus_wr_data   FIFO q: write data
//     bus_rd_data   read response data, held until the next read response
//     bus_rd_vld    one-cycle strobe qualifying bus_rd_data
//     reg_req       register request, high until ack or timeout
//     reg_rd_wr_L   captured read/write flag
//     reg_addr      captured address
//     reg_wr_data   captured write data
//     reg_ack       one-cycle acknowledge from the register group
//     reg_rd_data   read data, valid with reg_ack
//     timeout_cnt   saturating count of timed-out accesses
// ---------------------------------------------------------------------------
module jtag_reg_master
  import jtag_reg_master_pkg::*;
#(
  parameter int                             CPCI_NF2_ADDR_WIDTH = 27,
  parameter int                             CPCI_NF2_DATA_WIDTH = 32,
  parameter int                             TIMEOUT_CYCLES      = 1024,
  parameter logic [CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_RD_DATA     =
    CPCI_NF2_DATA_WIDTH'(TIMEOUT_RD_DATA_DEFAULT)
) (
  input  logic                           core_clk,
  input  logic                           reset,
  // request FIFO side
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic                           bus_rd_wr_L,
  input  logic [CPCI_NF2_ADDR_WIDTH-1:0] bus_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] bus_wr_data,
  // read response to jtag_bus
  output logic [CPCI_NF2_DATA_WIDTH-1:0] bus_rd_data,
  output logic                           bus_rd_vld,
  // register interface
  output logic                           reg_req,
  output logic                           reg_rd_wr_L,
  output logic [CPCI_NF2_ADDR_WIDTH-1:0] reg_addr,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_wr_data,
  input  logic                           reg_ack,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_rd_data,
  // status
  output logic [TIMEOUT_CNT_W-1:0]       timeout_cnt
);

  state_e                           r_state;
  logic                             r_reg_req;
  logic                             r_rd_wr_L;
  logic [CPCI_NF2_ADDR_WIDTH-1:0]   r_addr;
  logic [CPCI_NF2_DATA_WIDTH-1:0]   r_wr_data;
  logic                             r_rd_vld;
  logic [CPCI_NF2_DATA_WIDTH-1:0]   r_rd_data;
  logic [TIMEOUT_CNT_W-1:0]         r_timeout_cnt;

  logic                             w_pop;
  logic                             w_timer_en;
  logic                             w_expire;

  // Pop only from IDLE with data present. Gated by reset so the FIFO is never
  // popped while the FSM is held in IDLE by reset.
  assign w_pop      = (r_state == ST_IDLE) && !fifo_empty && !reset;
  assign w_timer_en = (r_state == ST_REQ);

  jtag_req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (core_clk),
    .i_rst    (reset),
    .i_clr    (w_pop),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_reg_req     <= 1'b0;
      r_rd_wr_L     <= 1'b1;
      r_addr        <= '0;
      r_wr_data     <= '0;
      r_rd_vld      <= 1'b0;
      r_rd_data     <= '0;
      r_timeout_cnt <= '0;
    end else begin
      // Read strobe is a single-cycle pulse; only the REQ exit raises it.
      r_rd_vld <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            // Capture the show-ahead FIFO head; held for the whole access.
            r_rd_wr_L <= bus_rd_wr_L;
            r_addr    <= bus_addr;
            r_wr_data <= bus_wr_data;
            r_reg_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Ack is checked first so an ack on the last timeout cycle still
          // returns real data and is not counted as a timeout.
          if (reg_ack) begin
            r_reg_req <= 1'b0;
            r_rd_vld  <= r_rd_wr_L;
            if (r_rd_wr_L) begin
              r_rd_data <= reg_rd_data;
            end
            r_state <= ST_RESP;
          end else if (w_expire) begin
            r_reg_req <= 1'b0;
            r_rd_vld  <= r_rd_wr_L;
            if (r_rd_wr_L) begin
              r_rd_data <= TIMEOUT_RD_DATA;
            end
            r_timeout_cnt <= sat_inc(r_timeout_cnt);
            r_state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_state <= ST_GAP;
        end

        ST_GAP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en  = w_pop;
  assign reg_req     = r_reg_req;
  assign reg_rd_wr_L = r_rd_wr_L;
  assign reg_addr    = r_addr;
  assign reg_wr_data = r_wr_data;
  assign bus_rd_vld  = r_rd_vld;
  assign bus_rd_data = r_rd_data;
  assign timeout_cnt = r_timeout_cnt;

endmodule
